// File: rtl/pipeline_debug_pkg.sv
// Shared constants and state encoding for the pipeline debug sequencer.
package pipeline_debug_pkg;

  localparam logic [7:0] CMD_CONT = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_DUMP = 8'h64;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_IDX_W     = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    STEP = 3'd2,
    LOAD = 3'd3,
    SEND = 3'd4,
    WAIT = 3'd5
  } state_e;

endpackage

// File: rtl/debug_byte_serializer.sv
// Sends one 32-bit word MSB-first as four bytes over the UART tx handshake.
// i_word is sampled live in each SEND cycle, so the caller keeps it valid
// for the whole word. o_word_done_c is a same-cycle strobe on the last tx_done.
module debug_byte_serializer
  import pipeline_debug_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] i_word,
  input  logic        i_load,
  input  logic        i_tx_done,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  output logic        o_word_done_c
);

  state_e                r_state, w_state_nxt;
  logic [BYTE_IDX_W-1:0] r_byte_idx, w_byte_idx_nxt;
  logic [7:0]            r_tx_data, w_tx_data_nxt;
  logic                  r_tx_start, w_tx_start_nxt;
  logic [7:0]            w_sel_byte;
  logic                  w_last_byte;

  assign w_last_byte = (r_byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = r_tx_start;

  // Byte select, index 0 is the most significant byte.
  always_comb begin
    w_sel_byte = i_word[31:24];
    case (r_byte_idx)
      2'd1:    w_sel_byte = i_word[23:16];
      2'd2:    w_sel_byte = i_word[15:8];
      2'd3:    w_sel_byte = i_word[7:0];
      default: w_sel_byte = i_word[31:24];
    endcase
  end

  // Serializer state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_byte_idx <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_start <= w_tx_start_nxt;
    end
  end

  // SEND/WAIT byte loop; a load restarts at byte 0 even on the done cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_idx_nxt = r_byte_idx;
    w_tx_data_nxt  = r_tx_data;
    w_tx_start_nxt = 1'b0;
    o_word_done_c  = 1'b0;
    case (r_state)
      SEND: begin
        w_tx_data_nxt  = w_sel_byte;
        w_tx_start_nxt = 1'b1;
        w_state_nxt    = WAIT;
      end
      WAIT: begin
        if (i_tx_done) begin
          if (w_last_byte) begin
            o_word_done_c = 1'b1;
            w_state_nxt   = IDLE;
          end else begin
            w_byte_idx_nxt = r_byte_idx + BYTE_IDX_W'(1);
            w_state_nxt    = SEND;
          end
        end
      end
      default: ;
    endcase
    if (i_load) begin
      w_state_nxt    = SEND;
      w_byte_idx_nxt = '0;
    end
  end

endmodule

// File: rtl/pipeline_run_controller.sv
// Debug sequencer: decodes UART commands, gates the pipeline clock enable
// for run/step, and streams a status-word report when the pipeline stops.
// Optional macro PIPE_CYCLE_COUNT_EN prefixes the report with a saturating
// count of enabled pipeline cycles since reset.
module pipeline_run_controller
  import pipeline_debug_pkg::*;
#(
  parameter int unsigned STATUS_WORDS = 16,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  input  logic              halt,
  output logic              pipe_enable,
  output logic [ADDR_W-1:0] status_addr,
  input  logic [31:0]       status_data,
  output logic              busy
);

  state_e            r_state, w_state_nxt;
  logic              r_pipe_enable, w_pipe_enable_nxt;
  logic [ADDR_W-1:0] r_status_addr, w_status_addr_nxt;
  logic              r_busy;
  logic              w_load;
  logic              w_word_done;
  logic              w_hdr;
  logic [31:0]       w_word;

  assign pipe_enable = r_pipe_enable;
  assign status_addr = r_status_addr;
  assign busy        = r_busy;

`ifdef PIPE_CYCLE_COUNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_cnt_snap;
  logic        r_hdr;

  // Enabled-cycle counter, snapshot at LOAD, and header-word phase flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle_cnt <= '0;
      r_cnt_snap  <= '0;
      r_hdr       <= 1'b0;
    end else begin
      if (r_pipe_enable && (r_cycle_cnt != 32'hFFFF_FFFF))
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (r_state == LOAD) begin
        r_cnt_snap <= r_cycle_cnt;
        r_hdr      <= 1'b1;
      end else if (w_word_done) begin
        r_hdr <= 1'b0;
      end
    end
  end

  assign w_hdr  = r_hdr;
  assign w_word = r_hdr ? r_cnt_snap : status_data;
`else
  assign w_hdr  = 1'b0;
  assign w_word = status_data;
`endif

  debug_byte_serializer u_ser (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_word        (w_word),
    .i_load        (w_load),
    .i_tx_done     (tx_done),
    .o_tx_data     (tx_data),
    .o_tx_start    (tx_start),
    .o_word_done_c (w_word_done)
  );

  // Controller state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_pipe_enable <= 1'b0;
      r_status_addr <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pipe_enable <= w_pipe_enable_nxt;
      r_status_addr <= w_status_addr_nxt;
      r_busy        <= (w_state_nxt != IDLE);
    end
  end

  // Command decode, run/step gating and word sequencing.
  always_comb begin
    w_state_nxt       = r_state;
    w_pipe_enable_nxt = r_pipe_enable;
    w_status_addr_nxt = r_status_addr;
    w_load            = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_done) begin
          case (rx_data)
            CMD_CONT: begin
              w_state_nxt       = halt ? LOAD : RUN;
              w_pipe_enable_nxt = !halt;
            end
            CMD_STEP: begin
              w_state_nxt       = halt ? LOAD : STEP;
              w_pipe_enable_nxt = !halt;
            end
            CMD_DUMP: w_state_nxt = LOAD;
            default:  ;
          endcase
        end
      end
      RUN: begin
        if (halt) begin
          w_pipe_enable_nxt = 1'b0;
          w_state_nxt       = LOAD;
        end
      end
      STEP: begin
        w_pipe_enable_nxt = 1'b0;
        w_state_nxt       = LOAD;
      end
      LOAD: begin
        w_status_addr_nxt = '0;
        w_load            = 1'b1;
        w_state_nxt       = SEND;
      end
      SEND: w_state_nxt = WAIT;
      WAIT: begin
        if (w_word_done) begin
          if (!w_hdr && (r_status_addr == ADDR_W'(STATUS_WORDS - 1))) begin
            w_state_nxt = IDLE;
          end else begin
            if (!w_hdr)
              w_status_addr_nxt = r_status_addr + ADDR_W'(1);
            w_load      = 1'b1;
            w_state_nxt = SEND;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench for pipeline_run_controller with a byte scoreboard.
// Honours PIPE_CYCLE_COUNT_EN the same way as the design build.
module tb_pipeline_run_controller;
  import pipeline_debug_pkg::*;

  localparam int unsigned SW = 2;
  localparam int unsigned AW = 4;
  localparam logic [31:0] WORD0 = 32'h1122_3344;
  localparam logic [31:0] WORD1 = 32'hA5A5_0001;
`ifdef PIPE_CYCLE_COUNT_EN
  localparam int REPORT_BYTES = 4 * SW + 4;
`else
  localparam int REPORT_BYTES = 4 * SW;
`endif

  logic          clock;
  logic          reset_n;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_done;
  logic          halt;
  logic          pipe_enable;
  logic [AW-1:0] status_addr;
  logic [31:0]   status_data;
  logic          busy;

  int errors = 0;
  int checks = 0;
  logic [7:0]  exp_q[$];
  int unsigned exp_cycles = 0;
  logic        inject_rx = 1'b0;
  logic        watch_pe  = 1'b0;
  logic        pe_seen   = 1'b0;

  pipeline_run_controller #(.STATUS_WORDS(SW), .ADDR_W(AW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .halt        (halt),
    .pipe_enable (pipe_enable),
    .status_addr (status_addr),
    .status_data (status_data),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Status memory model seen by the controller.
  always_comb begin
    status_data = 32'hDEAD_BEEF;
    if (status_addr == AW'(0)) status_data = WORD0;
    else if (status_addr == AW'(1)) status_data = WORD1;
  end

  // Flags any pipe_enable while watching halted-command behaviour.
  always @(negedge clock) if (watch_pe && pipe_enable) pe_seen <= 1'b1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic push_report();
`ifdef PIPE_CYCLE_COUNT_EN
    push_word(32'(exp_cycles));
`endif
    push_word(WORD0);
    push_word(WORD1);
  endtask

  // Waits for tx_start with a bound; returns whether it was seen.
  task automatic wait_start(input string tag, output logic seen);
    int n = 0;
    while (!tx_start && n < 50) begin
      tick();
      n++;
    end
    seen = tx_start;
    chk({tag, "_start_seen"}, 32'(seen), 32'd1);
  endtask

  // Receives n bytes, answering each tx_start with tx_done 10 cycles later.
  task automatic expect_bytes(input string tag, input int n, input logic full);
    logic       seen;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      wait_start(tag, seen);
      if (!seen) return;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      chk({tag, "_byte"}, 32'(tx_data), 32'(e));
      tick();
      chk({tag, "_start_pulse"}, 32'(tx_start), 32'd0);
      if (inject_rx && i == 1) begin
        send_rx(CMD_DUMP);
        repeat (7) tick();
      end else begin
        repeat (8) tick();
      end
      chk({tag, "_hold"}, 32'(tx_data), 32'(e));
      chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    if (full) begin
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    end
  endtask

  // Confirms the controller stays idle with no transmit activity.
  task automatic expect_quiet(input string tag, input int cycles);
    logic act = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (tx_start || busy || pipe_enable) act = 1'b1;
    end
    chk({tag, "_quiet"}, 32'(act), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_pipe_en"}, 32'(pipe_enable), 32'd0);
    chk({tag, "_addr"}, 32'(status_addr), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic seen;
    logic dropped;
    reset_n = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    halt    = 1'b0;
    tick();
    tick();
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    tick();

    // Unknown command and a stray tx_done while idle.
    send_rx(8'h7A);
    chk("unknown_busy", 32'(busy), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    expect_quiet("unknown", 5);

    // Plain dump.
    push_report();
    send_rx(CMD_DUMP);
    chk("dump_busy", 32'(busy), 32'd1);
    chk("dump_pe", 32'(pipe_enable), 32'd0);
    expect_bytes("dump", REPORT_BYTES, 1'b1);
    expect_quiet("dump", 5);

    // Single step, with a command arriving mid-report.
    exp_cycles += 1;
    push_report();
    send_rx(CMD_STEP);
    chk("step_pe_on", 32'(pipe_enable), 32'd1);
    tick();
    chk("step_pe_off", 32'(pipe_enable), 32'd0);
    chk("step_busy", 32'(busy), 32'd1);
    inject_rx = 1'b1;
    expect_bytes("step", REPORT_BYTES, 1'b1);
    inject_rx = 1'b0;
    expect_quiet("step", 20);

    // Continuous run halted 37 cycles later.
    send_rx(CMD_CONT);
    chk("cont_pe_on", 32'(pipe_enable), 32'd1);
    dropped = 1'b0;
    repeat (36) begin
      tick();
      if (!pipe_enable) dropped = 1'b1;
    end
    chk("cont_pe_held", 32'(dropped), 32'd0);
    chk("cont_busy_run", 32'(busy), 32'd1);
    halt = 1'b1;
    tick();
    chk("cont_pe_off", 32'(pipe_enable), 32'd0);
    exp_cycles += 37;
    push_report();
    expect_bytes("cont", REPORT_BYTES, 1'b1);

    // Halt already set: commands only produce a dump.
    watch_pe = 1'b1;
    push_report();
    send_rx(CMD_CONT);
    chk("hcont_busy", 32'(busy), 32'd1);
    expect_bytes("hcont", REPORT_BYTES, 1'b1);
    expect_quiet("hcont", 8);
    push_report();
    send_rx(CMD_STEP);
    chk("hstep_busy", 32'(busy), 32'd1);
    expect_bytes("hstep", REPORT_BYTES, 1'b1);
    expect_quiet("hstep", 8);
    watch_pe = 1'b0;
    chk("halted_pe_never", 32'(pe_seen), 32'd0);

    // Reset during the third byte, then a fresh dump.
    halt = 1'b0;
    push_report();
    send_rx(CMD_DUMP);
    expect_bytes("abort", 2, 1'b0);
    wait_start("abort3", seen);
    #2;
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    exp_q.delete();
    exp_cycles = 0;
    tick();
    reset_n = 1'b1;
    tick();
    chk_outputs_zero("post_rst");
    push_report();
    send_rx(CMD_DUMP);
    chk("restart_addr", 32'(status_addr), 32'd0);
    expect_bytes("restart", REPORT_BYTES, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
